// File: rtl/ahblite_copy_master.sv
// AHB-Lite bus master that copies a block of 32-bit words from src to dst,
// one SINGLE read followed by one SINGLE write per word, with no pipelining.
module ahblite_copy_master #(
    parameter int LEN_W = 16
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    input  logic             start,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [LEN_W-1:0] words_left,
    output logic [31:0]      HADDR,
    output logic [1:0]       HTRANS,
    output logic             HWRITE,
    output logic [2:0]       HSIZE,
    output logic [2:0]       HBURST,
    output logic [3:0]       HPROT,
    output logic             HMASTLOCK,
    output logic [31:0]      HWDATA,
    input  logic             HREADY,
    input  logic             HRESP,
    input  logic [31:0]      HRDATA
);

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR_ADDR,
        WR_DATA
    } state_t;

    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;

    state_t      state;
    state_t      state_next;
    logic [31:0] src_ptr;
    logic [31:0] dst_ptr;
    logic [31:0] data_buf;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // An ERROR response ends the copy on its second (HREADY=1) cycle.
    always_comb begin
        state_next = state;
        HTRANS     = TRANS_IDLE;
        HWRITE     = 1'b0;
        HADDR      = 32'h0;
        case (state)
            IDLE: begin
                if (start && (len != '0)) begin
                    state_next = RD_ADDR;
                end
            end
            RD_ADDR: begin
                HTRANS = TRANS_NONSEQ;
                HADDR  = src_ptr;
                if (HREADY) begin
                    state_next = RD_DATA;
                end
            end
            RD_DATA: begin
                HADDR = src_ptr;
                if (HREADY) begin
                    state_next = HRESP ? IDLE : WR_ADDR;
                end
            end
            WR_ADDR: begin
                HTRANS = TRANS_NONSEQ;
                HWRITE = 1'b1;
                HADDR  = dst_ptr;
                if (HREADY) begin
                    state_next = WR_DATA;
                end
            end
            WR_DATA: begin
                HWRITE = 1'b1;
                HADDR  = dst_ptr;
                if (HREADY) begin
                    state_next = (HRESP || (words_left == LEN_W'(1))) ? IDLE : RD_ADDR;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            src_ptr    <= 32'h0;
            dst_ptr    <= 32'h0;
            data_buf   <= 32'h0;
            words_left <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        src_ptr    <= {src_addr[31:2], 2'b00};
                        dst_ptr    <= {dst_addr[31:2], 2'b00};
                        words_left <= len;
                        if (len == '0) begin
                            done <= 1'b1;
                        end
                    end
                end
                RD_DATA: begin
                    if (HREADY) begin
                        if (HRESP) begin
                            err <= 1'b1;
                        end else begin
                            data_buf <= HRDATA;
                        end
                    end
                end
                WR_DATA: begin
                    if (HREADY) begin
                        if (HRESP) begin
                            err <= 1'b1;
                        end else begin
                            src_ptr    <= src_ptr + 32'd4;
                            dst_ptr    <= dst_ptr + 32'd4;
                            words_left <= words_left - LEN_W'(1);
                            if (words_left == LEN_W'(1)) begin
                                done <= 1'b1;
                            end
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy      = (state != IDLE);
    assign HWDATA    = data_buf;
    assign HSIZE     = 3'b010;
    assign HBURST    = 3'b000;
    assign HPROT     = 4'b0011;
    assign HMASTLOCK = 1'b0;

endmodule

// File: tb/tb_ahblite_copy_master.sv
// Bench for ahblite_copy_master: behavioural AHB-Lite memory slave with wait/error
// injection, and a scoreboard of expected read addresses and write address/data.
module tb_ahblite_copy_master;

    localparam int LEN_W = 16;

    logic             HCLK;
    logic             HRESETn;
    logic             start;
    logic [31:0]      src_addr;
    logic [31:0]      dst_addr;
    logic [LEN_W-1:0] len;
    logic             busy;
    logic             done;
    logic             err;
    logic [LEN_W-1:0] words_left;
    logic [31:0]      HADDR;
    logic [1:0]       HTRANS;
    logic             HWRITE;
    logic [2:0]       HSIZE;
    logic [2:0]       HBURST;
    logic [3:0]       HPROT;
    logic             HMASTLOCK;
    logic [31:0]      HWDATA;
    logic             HREADY;
    logic             HRESP;
    logic [31:0]      HRDATA;

    ahblite_copy_master #(.LEN_W(LEN_W)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .start(start),
        .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
        .busy(busy), .done(done), .err(err), .words_left(words_left),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
        .HBURST(HBURST), .HPROT(HPROT), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA),
        .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    int check_count = 0;
    int fail_count  = 0;

    logic [31:0] mem [logic [31:0]];
    logic [31:0] exp_rd_q [$];
    logic [31:0] exp_wr_addr_q [$];
    logic [31:0] exp_wr_data_q [$];
    logic [31:0] src_data [8];

    int wait_cfg, err_read_idx, read_idx;
    int nonseq_count, busy_cycles, done_count, err_seen, wr_count, overlap;
    bit dp_active, dp_write, dp_err;
    int wait_left, err_step;
    logic [31:0] dp_addr, dp_exp_addr, dp_exp_data;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    // Slave decides its response at the falling edge and predicts what the
    // master will see at the following rising edge (DUT outputs are stable then).
    always @(negedge HCLK) begin
        if (!HRESETn) begin
            dp_active = 0;
            HREADY    = 1'b1;
            HRESP     = 1'b0;
        end else begin
            if (busy) busy_cycles++;
            if (done) done_count++;
            if (err) err_seen++;
            if (done && err) overlap++;

            if (!dp_active) begin
                HREADY = 1'b1; HRESP = 1'b0;
            end else if (dp_err) begin
                if (err_step == 0) begin
                    HREADY = 1'b0; HRESP = 1'b1; err_step = 1;
                end else begin
                    HREADY = 1'b1; HRESP = 1'b1;
                end
            end else if (wait_left > 0) begin
                HREADY = 1'b0; HRESP = 1'b0; wait_left--;
            end else begin
                HREADY = 1'b1; HRESP = 1'b0;
                if (!dp_write) HRDATA = mem.exists(dp_addr) ? mem[dp_addr] : 32'hDEADBEEF;
            end

            if (dp_active && !HREADY && !HRESP) begin
                checkOutput("wait_haddr", HADDR, dp_exp_addr);
                if (dp_write) checkOutput("wait_hwdata", HWDATA, dp_exp_data);
            end

            if (dp_active && HREADY) begin
                if (dp_write && !HRESP) begin
                    mem[dp_addr] = HWDATA;
                    wr_count++;
                    checkOutput("wr_pending", 32'(exp_wr_data_q.size() != 0), 1);
                    if (exp_wr_data_q.size() != 0) begin
                        checkOutput("wr_data", HWDATA, exp_wr_data_q.pop_front());
                        void'(exp_wr_addr_q.pop_front());
                    end
                end
                dp_active = 0;
            end

            if (HREADY && HTRANS == 2'b10) begin
                nonseq_count++;
                dp_active = 1; dp_write = HWRITE; dp_addr = HADDR;
                wait_left = wait_cfg; err_step = 0; dp_err = 0;
                dp_exp_addr = 32'h0; dp_exp_data = 32'h0;
                if (HWRITE) begin
                    checkOutput("wr_accept", 32'(exp_wr_addr_q.size() != 0), 1);
                    if (exp_wr_addr_q.size() != 0) begin
                        dp_exp_addr = exp_wr_addr_q[0];
                        dp_exp_data = exp_wr_data_q[0];
                        checkOutput("wr_addr", HADDR, dp_exp_addr);
                    end
                end else begin
                    checkOutput("rd_accept", 32'(exp_rd_q.size() != 0), 1);
                    if (exp_rd_q.size() != 0) begin
                        dp_exp_addr = exp_rd_q.pop_front();
                        checkOutput("rd_addr", HADDR, dp_exp_addr);
                    end
                    dp_err = (read_idx == err_read_idx);
                    read_idx++;
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge HCLK);
        #1;
    endtask

    task automatic pulseStart(input logic [31:0] src, input logic [31:0] dst, input int n);
        @(negedge HCLK);
        start = 1'b1; src_addr = src; dst_addr = dst; len = LEN_W'(n);
        @(negedge HCLK);
        start = 1'b0;
        #1;
    endtask

    // Pushes the expected bus traffic for one copy, then requests it.
    task automatic applyStimulus(input logic [31:0] src, input logic [31:0] dst,
                                 input int n, input int w, input int err_idx);
        logic [31:0] s, d, off;
        s = {src[31:2], 2'b00};
        d = {dst[31:2], 2'b00};
        wait_cfg = w; err_read_idx = err_idx; read_idx = 0;
        nonseq_count = 0; busy_cycles = 0; done_count = 0; err_seen = 0;
        wr_count = 0; overlap = 0;
        for (int i = 0; i < n; i++) begin
            off = 32'(i) * 32'd4;
            mem[s + off] = src_data[i];
            if (err_idx < 0 || i <= err_idx) exp_rd_q.push_back(s + off);
            if (err_idx < 0 || i < err_idx) begin
                exp_wr_addr_q.push_back(d + off);
                exp_wr_data_q.push_back(src_data[i]);
            end
        end
        pulseStart(src, dst, n);
    endtask

    task automatic waitForEnd(input int budget);
        for (int i = 0; i < budget && (done_count + err_seen) == 0; i++) begin
            @(negedge HCLK);
            #1;
        end
        checkOutput("end_seen", 32'((done_count + err_seen) != 0), 1);
        idle(3);
    endtask

    task automatic checkQueuesEmpty();
        checkOutput("rd_q_empty", 32'(exp_rd_q.size()), 0);
        checkOutput("wr_q_empty", 32'(exp_wr_addr_q.size()), 0);
        checkOutput("overlap", 32'(overlap), 0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        HRESETn = 1'b0; start = 1'b0; src_addr = 32'h0; dst_addr = 32'h0; len = '0;
        HREADY = 1'b1; HRESP = 1'b0; HRDATA = 32'h0;
        wait_cfg = 0; err_read_idx = -1; read_idx = 0;
        idle(2);
        checkOutput("rst_htrans", 32'(HTRANS), 0);
        checkOutput("rst_haddr", HADDR, 0);
        checkOutput("rst_hwrite", 32'(HWRITE), 0);
        checkOutput("rst_hwdata", HWDATA, 0);
        checkOutput("rst_status", {29'd0, busy, done, err}, 0);
        checkOutput("rst_words_left", 32'(words_left), 0);
        checkOutput("const_ctrl", {17'd0, HSIZE, HBURST, HPROT, HMASTLOCK, 4'd0}, {17'd0, 3'b010, 3'b000, 4'b0011, 1'b0, 4'd0});
        #1 HRESETn = 1'b1;
        idle(2);

        $display("[TB] test 1: zero-wait copy");
        src_data[0] = 32'hA1; src_data[1] = 32'hB2; src_data[2] = 32'hC3;
        applyStimulus(32'h2000_0000, 32'h2000_0100, 3, 0, -1);
        waitForEnd(100);
        checkOutput("t1_nonseq", 32'(nonseq_count), 6);
        checkOutput("t1_busy", 32'(busy_cycles), 12);
        checkOutput("t1_done", 32'(done_count), 1);
        checkOutput("t1_err", 32'(err_seen), 0);
        checkOutput("t1_words_left", 32'(words_left), 0);
        for (int i = 0; i < 3; i++) checkOutput("t1_mem", mem[32'h2000_0100 + 32'(i) * 32'd4], src_data[i]);
        checkQueuesEmpty();

        $display("[TB] test 2: two wait states per data phase, unaligned src");
        for (int i = 0; i < 3; i++) src_data[i] = $urandom;
        applyStimulus(32'h2000_1003, 32'h2000_1100, 3, 2, -1);
        waitForEnd(200);
        checkOutput("t2_busy", 32'(busy_cycles), 24);
        checkOutput("t2_done", 32'(done_count), 1);
        checkOutput("t2_writes", 32'(wr_count), 3);
        checkQueuesEmpty();

        $display("[TB] test 3: error on second read");
        for (int i = 0; i < 3; i++) src_data[i] = $urandom;
        applyStimulus(32'h2000_2000, 32'h2000_2100, 3, 0, 1);
        waitForEnd(100);
        checkOutput("t3_err", 32'(err_seen), 1);
        checkOutput("t3_done", 32'(done_count), 0);
        checkOutput("t3_writes", 32'(wr_count), 1);
        checkOutput("t3_nonseq", 32'(nonseq_count), 3);
        checkOutput("t3_words_left", 32'(words_left), 2);
        checkOutput("t3_htrans", 32'(HTRANS), 0);
        checkQueuesEmpty();

        $display("[TB] test 4: zero length");
        applyStimulus(32'h2000_3000, 32'h2000_3100, 0, 0, -1);
        checkOutput("t4_done_next", 32'(done), 1);
        idle(4);
        checkOutput("t4_done", 32'(done_count), 1);
        checkOutput("t4_busy", 32'(busy_cycles), 0);
        checkOutput("t4_nonseq", 32'(nonseq_count), 0);

        $display("[TB] test 5: start ignored while busy, then async reset");
        for (int i = 0; i < 3; i++) src_data[i] = $urandom;
        applyStimulus(32'h2000_4000, 32'h2000_4100, 3, 0, -1);
        idle(3);
        pulseStart(32'h2000_5000, 32'h2000_5100, 1);
        waitForEnd(100);
        checkOutput("t5_done", 32'(done_count), 1);
        checkOutput("t5_writes", 32'(wr_count), 3);
        checkOutput("t5_busy", 32'(busy_cycles), 12);
        checkQueuesEmpty();
        src_data[0] = $urandom;
        applyStimulus(32'h2000_6000, 32'h2000_6100, 1, 3, -1);
        for (int i = 0; i < 50 && !(dp_active && dp_write); i++) idle(1);
        checkOutput("t5_wr_phase", 32'(dp_active && dp_write), 1);
        @(negedge HCLK);
        #2 HRESETn = 1'b0;
        #1;
        checkOutput("t5_rst_htrans", 32'(HTRANS), 0);
        checkOutput("t5_rst_status", {29'd0, busy, done, err}, 0);
        checkOutput("t5_rst_haddr", HADDR, 0);
        idle(2);
        #1 HRESETn = 1'b1;
        exp_rd_q.delete(); exp_wr_addr_q.delete(); exp_wr_data_q.delete();
        idle(6);
        checkOutput("t5_no_done", 32'(done_count), 0);
        checkOutput("t5_no_err", 32'(err_seen), 0);
        checkOutput("t5_no_write", 32'(wr_count), 0);
        checkOutput("t5_idle_busy", 32'(busy), 0);

        $display("[TB] test 6: source pointer wraps");
        src_data[0] = $urandom; src_data[1] = $urandom;
        applyStimulus(32'hFFFF_FFFC, 32'h3000_0000, 2, 0, -1);
        waitForEnd(100);
        checkOutput("t6_done", 32'(done_count), 1);
        checkOutput("t6_writes", 32'(wr_count), 2);
        checkOutput("t6_mem1", mem[32'h3000_0004], src_data[1]);
        checkQueuesEmpty();

        $display("Result: errors=%0d of %0d checks", fail_count, check_count);
        $finish;
    end

endmodule
